// File: rtl/hs32_fetch.sv
// hs32_fetch: AHB3-lite instruction prefetcher feeding hs32_pipeline through a small FIFO.
// Redirects and bus errors are absorbed here so the consumer only sees a clean in-order stream.
module hs32_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] op_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  input  logic        HREADY_i,
  input  logic        HRESP_i,
  input  logic [31:0] HRDATA_i,
  output logic [31:0] HADDR_o,
  output logic [1:0]  HTRANS_o,
  output logic        HWRITE_o,
  output logic [2:0]  HSIZE_o,
  output logic [2:0]  HBURST_o,
  output logic [3:0]  HPROT_o,
  output logic        HMASTLOCK_o,
  output logic [31:0] HWDATA_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = PW + 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  logic [31:0]   fpc_q, fpc_d;
  logic          aphase_q, aphase_d;
  logic [31:0]   haddr_q, haddr_d;
  logic          adisc_q, adisc_d;
  logic          dphase_q, dphase_d;
  logic [31:0]   dpc_q, dpc_d;
  logic          discard_q, discard_d;
  logic          err_q, err_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_op_q [DEPTH];
  logic [31:0]   fifo_op_d [DEPTH];

  logic          valid, issue, nonseq, accept, dcomplete, push, pop, held_stale;
  logic [31:0]   haddr;

  always_comb begin
    valid      = (count_q != '0);
    issue      = !reset && !fault_q && !redirect_i &&
                 ((SW'(count_q) + SW'(dphase_q)) < SW'(DEPTH));
    // err_q cancels a held address: AHB lets the master go IDLE after an ERROR response.
    nonseq     = !err_q && (aphase_q || issue);
    haddr      = aphase_q ? haddr_q : fpc_q;
    accept     = nonseq && HREADY_i;
    dcomplete  = dphase_q && HREADY_i;
    held_stale = aphase_q && adisc_q;
    push       = dcomplete && !HRESP_i && !discard_q && !redirect_i;
    pop        = valid && ready_i && !redirect_i;
  end

  always_comb begin
    fpc_d     = fpc_q;
    dphase_d  = dphase_q;
    dpc_d     = dpc_q;
    discard_d = discard_q;
    err_d     = err_q;
    fault_d   = fault_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    fifo_pc_d = fifo_pc_q;
    fifo_op_d = fifo_op_q;

    aphase_d = nonseq && !HREADY_i;
    haddr_d  = haddr;
    adisc_d  = aphase_d && (held_stale || redirect_i);

    if (accept) begin
      dphase_d  = 1'b1;
      dpc_d     = haddr;
      discard_d = held_stale || redirect_i || (dphase_q && HRESP_i);
    end else if (dcomplete) begin
      dphase_d  = 1'b0;
      discard_d = 1'b0;
    end else if (dphase_q && redirect_i) begin
      discard_d = 1'b1;
    end

    if (dcomplete)
      err_d = 1'b0;
    else if (dphase_q && HRESP_i)
      err_d = 1'b1;

    if (redirect_i)
      fpc_d = target_i & 32'hFFFF_FFFC;
    else if (accept && !held_stale)
      fpc_d = haddr + 32'd4;

    if (redirect_i)
      fault_d = 1'b0;
    else if (dcomplete && HRESP_i && !discard_q)
      fault_d = 1'b1;

    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q] = dpc_q;
        fifo_op_d[wr_ptr_q] = HRDATA_i;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      aphase_q  <= 1'b0;
      haddr_q   <= RESET_PC;
      adisc_q   <= 1'b0;
      dphase_q  <= 1'b0;
      dpc_q     <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      fifo_pc_q <= '{default: '0};
      fifo_op_q <= '{default: '0};
    end else begin
      fpc_q     <= fpc_d;
      aphase_q  <= aphase_d;
      haddr_q   <= haddr_d;
      adisc_q   <= adisc_d;
      dphase_q  <= dphase_d;
      dpc_q     <= dpc_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      fault_q   <= fault_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      fifo_pc_q <= fifo_pc_d;
      fifo_op_q <= fifo_op_d;
    end
  end

  assign valid_o     = valid;
  assign op_o        = valid ? fifo_op_q[rd_ptr_q] : '0;
  assign pc_o        = valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign fault_o     = fault_q;
  assign HADDR_o     = haddr;
  assign HTRANS_o    = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE_o    = 1'b0;
  assign HSIZE_o     = 3'b010;
  assign HBURST_o    = 3'b000;
  assign HPROT_o     = 4'b0010;
  assign HMASTLOCK_o = 1'b0;
  assign HWDATA_o    = '0;

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: AHB slave with wait states/errors plus a transaction-level
// model of the expected instruction stream, compared every cycle.
module tb_hs32_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] op_o, pc_o;
  logic        fault_o;
  logic        HREADY_i = 1'b1;
  logic        HRESP_i = 1'b0;
  logic [31:0] HRDATA_i = '0;
  logic [31:0] HADDR_o;
  logic [1:0]  HTRANS_o;
  logic        HWRITE_o;
  logic [2:0]  HSIZE_o;
  logic [2:0]  HBURST_o;
  logic [3:0]  HPROT_o;
  logic        HMASTLOCK_o;
  logic [31:0] HWDATA_o;

  always #5 clk = ~clk;

  hs32_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .target_i(target_i),
    .valid_o(valid_o), .ready_i(ready_i), .op_o(op_o), .pc_o(pc_o), .fault_o(fault_o),
    .HREADY_i(HREADY_i), .HRESP_i(HRESP_i), .HRDATA_i(HRDATA_i),
    .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o), .HWRITE_o(HWRITE_o), .HSIZE_o(HSIZE_o),
    .HBURST_o(HBURST_o), .HPROT_o(HPROT_o), .HMASTLOCK_o(HMASTLOCK_o), .HWDATA_o(HWDATA_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // stimulus knobs
  logic        s_reset = 1'b1, s_redirect = 1'b0, s_ready = 1'b0;
  logic [31:0] s_target = '0;
  bit          stall = 0, err_en = 0;
  logic [31:0] err_addr = '0;
  int          wait_mode = 0;

  // reference model state
  logic [31:0] mq_pc[$], mq_op[$];
  bit          dp_valid, dp_err, dp_errcyc, dp_disc;
  logic [31:0] dp_addr;
  int          dp_tag, dp_wait;
  bit          held;
  logic [31:0] held_addr;
  int          held_tag;
  int          epoch = 0;
  bit          exp_fault, force_idle;
  logic [31:0] exp_fpc;
  int          xfer_n = 0;
  bit          armed = 0;
  int          cyc = 0;

  logic [31:0] log_pc[$], log_op[$];
  int          first_ns_cyc = -1, first_valid_cyc = -1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete(); mq_op.delete();
    dp_valid = 0; dp_err = 0; dp_errcyc = 0; dp_disc = 0; dp_wait = 0;
    held = 0; exp_fault = 0; force_idle = 0;
    exp_fpc = RESET_PC;
    epoch++;
  endtask

  task automatic check_update();
    bit          exp_v, exp_ns, do_pop, stale, old_dp_err, hr;
    logic [31:0] exp_addr;
    int          cur_tag;
    exp_addr = '0;
    cur_tag  = epoch;
    if (armed) begin
      exp_v = (mq_pc.size() > 0);
      chk("const_ctrl", 32'({HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, HMASTLOCK_o}),
          32'({1'b0, 3'b010, 3'b000, 4'b0010, 1'b0}));
      chk("hwdata", HWDATA_o, 32'h0);
      chk("valid_o", 32'(valid_o), 32'(exp_v));
      chk("pc_o", pc_o, exp_v ? mq_pc[0] : 32'h0);
      chk("op_o", op_o, exp_v ? mq_op[0] : 32'h0);
      chk("fault_o", 32'(fault_o), 32'(exp_fault));
      exp_ns = 0;
      if (force_idle) exp_ns = 0;
      else if (held) begin
        exp_ns = 1; exp_addr = held_addr; cur_tag = held_tag;
      end else if (!reset && !exp_fault && !redirect_i &&
                   (mq_pc.size() + int'(dp_valid) + 1 <= int'(DEPTH))) begin
        exp_ns = 1; exp_addr = exp_fpc; cur_tag = epoch;
      end
      chk("htrans", 32'(HTRANS_o), exp_ns ? 32'h2 : 32'h0);
      if (exp_ns) chk("haddr", HADDR_o, exp_addr);
      if (HTRANS_o == 2'b10 && first_ns_cyc < 0) first_ns_cyc = cyc;
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i && !redirect_i) begin
        log_pc.push_back(pc_o); log_op.push_back(op_o);
      end
    end else begin
      exp_v = 0; exp_ns = 0;
    end

    if (reset) begin
      model_reset();
      armed = 1;
      return;
    end
    if (!armed) return;

    hr = HREADY_i;
    old_dp_err = dp_valid && dp_err;
    do_pop = exp_v && ready_i && !redirect_i;
    if (do_pop) begin void'(mq_pc.pop_front()); void'(mq_op.pop_front()); end

    if (dp_valid && hr) begin
      stale = (dp_tag != epoch) || redirect_i || dp_disc;
      if (dp_err) begin
        if (!stale) exp_fault = 1;
      end else if (!stale) begin
        mq_pc.push_back(dp_addr); mq_op.push_back(mem(dp_addr));
      end
      dp_valid = 0;
      force_idle = 0;
    end else if (dp_valid) begin
      if (dp_err) begin dp_errcyc = 1; force_idle = 1; end
      else if (!stall && dp_wait > 0) dp_wait--;
    end

    if (exp_ns && hr) begin
      dp_valid = 1; dp_addr = exp_addr; dp_tag = cur_tag; dp_disc = old_dp_err;
      dp_err = err_en && (exp_addr == err_addr); dp_errcyc = 0;
      case (wait_mode)
        1:       dp_wait = (xfer_n % 3 == 2) ? 2 : 0;
        2:       dp_wait = int'($urandom_range(0, 2));
        default: dp_wait = 0;
      endcase
      xfer_n++;
      if (cur_tag == epoch) exp_fpc = exp_addr + 32'd4;
      held = 0;
    end else if (exp_ns) begin
      held = 1; held_addr = exp_addr; held_tag = cur_tag;
    end else begin
      held = 0;
    end

    if (redirect_i) begin
      mq_pc.delete(); mq_op.delete();
      exp_fpc = target_i & 32'hFFFF_FFFC;
      exp_fault = 0;
      epoch++;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    reset = s_reset; redirect_i = s_redirect; target_i = s_target; ready_i = s_ready;
    HRESP_i = 1'b0; HREADY_i = 1'b1; HRDATA_i = $urandom;
    if (dp_valid) begin
      if (dp_err) begin HRESP_i = 1'b1; HREADY_i = dp_errcyc; end
      else if (stall || dp_wait > 0) HREADY_i = 1'b0;
      else HRDATA_i = mem(dp_addr);
    end
    @(negedge clk);
    cyc++;
    check_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic int seq_breaks();
    int b = 0;
    for (int i = 1; i < log_pc.size(); i++)
      if (log_pc[i] != log_pc[i-1] + 32'd4 || log_op[i] != mem(log_pc[i])) b++;
    return b;
  endfunction

  task automatic do_reset();
    s_reset = 1; s_redirect = 0; stall = 0;
    run(2);
    chk("rst_htrans", 32'(HTRANS_o), 32'h0);
    chk("rst_haddr", HADDR_o, RESET_PC);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_fault", 32'(fault_o), 32'h0);
    chk("rst_op", op_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
  endtask

  initial begin
    int guard;
    // basic fetch
    s_ready = 1; wait_mode = 0;
    do_reset();
    log_pc.delete(); log_op.delete(); first_ns_cyc = -1; first_valid_cyc = -1;
    s_reset = 0;
    run(30);
    chk("first_valid_latency", 32'(first_valid_cyc - first_ns_cyc), 32'd2);
    chk("basic_count", 32'(log_pc.size()), 32'd28);
    if (log_pc.size() >= 2) begin
      chk("basic_pc0", log_pc[0], 32'h0);
      chk("basic_op0", log_op[0], 32'hA000_0000);
      chk("basic_pc1", log_pc[1], 32'h4);
      chk("basic_op1", log_op[1], 32'hA000_0001);
    end

    // backpressure
    s_ready = 0;
    run(10);
    chk("bp_buffered", 32'(mq_pc.size()), DEPTH);
    chk("bp_idle", 32'(HTRANS_o), 32'h0);
    chk("bp_valid", 32'(valid_o), 32'h1);
    s_ready = 1;
    run(20);
    chk("bp_seq_breaks", 32'(seq_breaks()), 32'd0);

    // wait states
    log_pc.delete(); log_op.delete();
    wait_mode = 1;
    run(60);
    chk("ws_seq_breaks", 32'(seq_breaks()), 32'd0);
    chk("ws_throughput_drop", 32'(log_pc.size() > 20 && log_pc.size() < 55), 32'd1);

    // redirect with two transfers in flight
    guard = 0;
    while (!(dp_valid && held) && guard < 40) begin cycle(); guard++; end
    chk("rd_inflight_found", 32'(guard < 40), 32'd1);
    s_redirect = 1; s_target = 32'h0000_0042;
    log_pc.delete(); log_op.delete();
    cycle();
    s_redirect = 0;
    cycle();
    chk("rd_valid_low", 32'(valid_o), 32'h0);
    guard = 0;
    while (log_pc.size() == 0 && guard < 30) begin cycle(); guard++; end
    chk("rd_timeout", 32'(guard < 30), 32'd1);
    if (log_pc.size() > 0) begin
      chk("rd_first_pc", log_pc[0], 32'h40);
      chk("rd_first_op", log_op[0], 32'hA000_0010);
    end

    // bus error on 0xC
    wait_mode = 0; err_en = 1; err_addr = 32'hC;
    do_reset();
    log_pc.delete(); log_op.delete();
    s_reset = 0;
    run(20);
    chk("err_fault", 32'(fault_o), 32'h1);
    chk("err_idle", 32'(HTRANS_o), 32'h0);
    chk("err_count", 32'(log_pc.size()), 32'd3);
    if (log_pc.size() >= 3) chk("err_last_pc", log_pc[2], 32'h8);
    err_en = 0;
    s_redirect = 1; s_target = 32'h0;
    cycle();
    s_redirect = 0;
    run(10);
    chk("err_cleared", 32'(fault_o), 32'h0);
    chk("err_resume", 32'(log_pc.size() > 3), 32'd1);
    if (log_pc.size() > 3) chk("err_resume_pc", log_pc[3], 32'h0);

    // reset while an address is held in a wait state
    run(5);
    stall = 1;
    run(3);
    chk("rw_held", 32'(HTRANS_o), 32'h2);
    s_reset = 1;
    cycle();
    stall = 0;
    cycle();
    chk("rw_htrans", 32'(HTRANS_o), 32'h0);
    chk("rw_haddr", HADDR_o, RESET_PC);
    chk("rw_valid", 32'(valid_o), 32'h0);
    chk("rw_op", op_o, 32'h0);
    s_reset = 0;
    cycle();
    chk("rw_restart_htrans", 32'(HTRANS_o), 32'h2);
    chk("rw_restart_haddr", HADDR_o, RESET_PC);

    // randomized traffic
    wait_mode = 2; err_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) err_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      s_ready    = ($urandom_range(0, 9) < 7);
      s_redirect = ($urandom_range(0, 39) == 0);
      s_target   = 32'($urandom_range(0, 1023));
      s_reset    = ($urandom_range(0, 499) == 0);
      stall      = ($urandom_range(0, 19) == 0);
      cycle();
    end
    s_reset = 0; s_redirect = 0; stall = 0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hs32_fetch.md
# hs32_fetch

Instruction fetch front-end for the HS32 core. It acts as an AHB3-lite master that reads sequential 32-bit instruction words starting at a programmable PC and buffers them in a small prefetch FIFO. The buffered words are presented to `hs32_pipeline` over its `valid_i`/`ready_o`/`op_i` handshake. Redirect and bus-error handling live here, so the pipeline only ever sees a clean, in-order instruction stream.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0: first fetch address after reset; word aligned.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `redirect_i`  in  1  flush the stream and restart fetch at `target_i`.
- `target_i`  in  32  redirect address; bits [1:0] ignored.
- `valid_o`  out  1  FIFO head is valid; goes to pipeline `valid_i`.
- `ready_i`  in  1  pipeline accepts the head; driven from pipeline `ready_o`.
- `op_o`  out  32  instruction word at the FIFO head.
- `pc_o`  out  32  address of `op_o`.
- `fault_o`  out  1  sticky bus-error flag; fetch is halted while it is set.
- `HREADY_i`, `HRESP_i`  in  1 each  AHB slave ready and error response.
- `HRDATA_i`  in  32  AHB read data.
- `HADDR_o`  out  32  AHB address.
- `HTRANS_o`  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- `HWRITE_o`  out  1  constant 0.
- `HSIZE_o`  out  3  constant 3'b010.
- `HBURST_o`  out  3  constant 3'b000.
- `HPROT_o`  out  4  constant 4'b0010 (opcode fetch, privileged).
- `HMASTLOCK_o`  out  1  constant 0.
- `HWDATA_o`  out  32  constant 0.

## Operation
- **Registered state:**
  - `fpc`: next fetch address.
  - `aphase`: a NONSEQ is being presented.
  - `dphase` plus `dpc`: a data phase is pending, and its address.
  - `discard`: drop the result of the pending data phase.
  - `fault`.
  - FIFO storage of {pc, op} with its count.
- **Issue:** present NONSEQ at `HADDR_o = fpc` when all of the following hold:
  - `!fault`
  - `!redirect_i`
  - count + `dphase` + 1 ≤ DEPTH, using registered values only
- **Address phase:**
  - Once NONSEQ is presented, `HTRANS_o`/`HADDR_o` are held until `HREADY_i` is sampled high (AHB rule), even across a redirect.
  - On acceptance: `dphase` ← 1, `dpc` ← `fpc`, `fpc` ← `fpc` + 4 (wraps modulo 2^32).
- **Data phase:**
  - Completes at the first edge with `HREADY_i` high.
  - If `!discard && !HRESP_i`, push {`dpc`, `HRDATA_i`}.
  - A new address phase may overlap the data phase, so at most 2 transfers are in flight.
- **Pop:** `valid_o && ready_i`. Push and pop in the same cycle leave the count unchanged. The credit rule makes overflow impossible, so a push into a full FIFO is never legal.
- **Redirect** (edge with `redirect_i` high):
  - FIFO count ← 0.
  - `fpc` ← {`target_i`[31:2], 2'b00}.
  - `fault` ← 0.
  - Any pending or still-held transfer is marked `discard`.
  - Redirect wins over a simultaneous push or pop.
- **Error:**
  - `HRESP_i` high during the data phase (first error cycle, `HREADY_i` low):
    - drive `HTRANS_o` IDLE from the next cycle;
    - set `fault` on the completing edge;
    - push nothing.
  - An address accepted while the erroring data phase was active is discarded.
  - `fault` clears only via redirect or reset.
- **Reset mid-transfer:** all state returns to reset values immediately. Bus wait states are not honoured across reset.

## Timing
- **Reset values:**
  - `HTRANS_o` 2'b00, `HADDR_o` RESET_PC.
  - `valid_o` 0, `fault_o` 0.
  - `op_o` 0, `pc_o` 0 when the FIFO is empty.
  - Constant outputs as listed in Interface.
- **Start:** the first cycle after `reset` deasserts drives NONSEQ at RESET_PC.
- **Latency with zero wait states:**
  - address accepted at edge N;
  - data captured at edge N+1;
  - `valid_o` high after edge N+1, i.e. 2 cycles after the first NONSEQ.
- **Throughput:** sustained 1 word/cycle with `ready_i` held high and DEPTH ≥ 3.
- **Outputs:** `valid_o`, `op_o` and `pc_o` are driven from registered FIFO state only, with no combinational path from `ready_i`.
- **Wait states:** each `HREADY_i`-low cycle delays capture by exactly 1 cycle.
- **Redirect:**
  - `valid_o` is low in the cycle after the redirect edge.
  - The first NONSEQ at the target appears in that cycle if no transfer is held, otherwise in the cycle after the held address is accepted.

## Test plan
- **Basic fetch:** reset, zero-wait memory with mem[k] = 32'hA000_0000+k, `ready_i` = 1 → `op_o` sequence A0000000, A0000001, … with `pc_o` 0, 4, 8, …; `valid_o` rises 2 cycles after the first NONSEQ and stays high.
- **Backpressure:** `ready_i` = 0 for 10 cycles → exactly DEPTH words buffered, `HTRANS_o` IDLE after that; release → words delivered in order with no loss or duplication.
- **Wait states:** `HREADY_i` low for 2 cycles on every third transfer → `HADDR_o`/`HTRANS_o` stable during wait cycles; stream contents still A0000000…; throughput drops accordingly.
- **Redirect:** `redirect_i` pulse with `target_i` = 32'h0000_0042 while 2 transfers are in flight → next delivered `pc_o` = 32'h40 with `op_o` = mem[16]; no stale word delivered.
- **Error:** `HRESP_i` asserted for the two-cycle error on the fetch at 32'hC → `fault_o` = 1 and no further NONSEQ; words at 0, 4, 8 still delivered; redirect to 0 clears `fault_o` and fetch resumes.
- **Reset mid-wait:** `reset` asserted while NONSEQ is held under `HREADY_i` low → all outputs at reset values the next cycle; fetch restarts at RESET_PC.
